sdram_port_arbiter: RTL and testbench

- Shares the single internal request/ack port of the SDRAM controller between NUM_PORTS requesters (CPU instruction/data, video fetch, DMA).
- Selects one requester at a time using round-robin. The granted port may keep the grant for up to MAX_HOLD back-to-back transactions, to exploit open rows.
- Registers the granted port's request fields and drives the controller's acc/we/adr/dat/sel inputs.
- Routes the controller's ack and read data back to the granted port only.

---
 rtl/sdram_arb_pkg.sv | 13 +
 rtl/sdram_port_arbiter_rr_pick.sv | 34 +++
 rtl/sdram_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and field widths for the SDRAM port arbiter and its round-robin picker.
package sdram_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int ADR_W = 32;
    localparam int DAT_W = 16;
    localparam int SEL_W = 2;

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from last_i+1, wrapping.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Doubling the vector turns the modulo scan into a plain upward search.
    logic [2*N-1:0] req2_s;
    logic [IDX_W:0] pos_s;

    assign req2_s = {req_i, req_i};

    // Scan offsets 1..N; the first hit wins, so last_i itself has lowest priority.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        pos_s   = '0;
        for (int off = 1; off <= N; off++) begin
            pos_s = {1'b0, last_i} + (IDX_W+1)'(off);
            if (!valid_o && req2_s[pos_s]) begin
                valid_o = 1'b1;
                idx_o   = (pos_s >= (IDX_W+1)'(N)) ? IDX_W'(pos_s - (IDX_W+1)'(N)) : IDX_W'(pos_s);
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the SDRAM controller request/ack port between NUM_PORTS requesters using
// round-robin with a bounded same-port hold to keep open rows busy.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int MAX_HOLD  = 4
) (
    input  logic                       sdram_clk,
    input  logic                       sdram_rst_n,
    input  logic [NUM_PORTS-1:0]       req_i,
    input  logic [NUM_PORTS-1:0]       we_i,
    input  logic [ADR_W*NUM_PORTS-1:0] adr_i,
    input  logic [DAT_W*NUM_PORTS-1:0] dat_i,
    input  logic [SEL_W*NUM_PORTS-1:0] sel_i,
    output logic [NUM_PORTS-1:0]       ack_o,
    output logic [DAT_W-1:0]           dat_o,
    output logic                       ctrl_acc_o,
    output logic                       ctrl_we_o,
    output logic [ADR_W-1:0]           ctrl_adr_o,
    output logic [DAT_W-1:0]           ctrl_dat_o,
    output logic [SEL_W-1:0]           ctrl_sel_o,
    input  logic                       ctrl_ack_i,
    input  logic [DAT_W-1:0]           ctrl_dat_i,
    output logic [NUM_PORTS-1:0]       grant_o
);

    localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [NUM_PORTS-1:0][ADR_W-1:0] adr_arr_s;
    logic [NUM_PORTS-1:0][DAT_W-1:0] dat_arr_s;
    logic [NUM_PORTS-1:0][SEL_W-1:0] sel_arr_s;

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic                  acc_q, acc_d;
    logic                  prev_busy_q, prev_busy_d;
    logic [NUM_PORTS-1:0]  gnt_oh_q, gnt_oh_d;
    logic                  we_q, we_d;
    logic [ADR_W-1:0]      adr_q, adr_d;
    logic [DAT_W-1:0]      dat_q, dat_d;
    logic [SEL_W-1:0]      sel_q, sel_d;

    logic [IDX_W-1:0]      pick_idx_s, win_s;
    logic                  pick_vld_s, win_vld_s, hold_ok_s;

    assign adr_arr_s = adr_i;
    assign dat_arr_s = dat_i;
    assign sel_arr_s = sel_i;

    rr_pick #(.N(NUM_PORTS), .IDX_W(IDX_W)) u_rr_pick (
        .req_i   (req_i),
        .last_i  (last_q),
        .idx_o   (pick_idx_s),
        .valid_o (pick_vld_s)
    );

    // The previous owner keeps the port only when it comes straight back from a transaction.
    always_comb begin
        hold_ok_s = prev_busy_q && req_i[last_q] && (hold_q < HOLD_W'(MAX_HOLD));
        if (hold_ok_s) begin
            win_s     = last_q;
            win_vld_s = 1'b1;
        end else begin
            win_s     = pick_idx_s;
            win_vld_s = pick_vld_s;
        end
    end

    // Next-state logic: latch the winner's fields in ARB, wait for the controller ack in BUSY.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_d      = hold_q;
        acc_d       = acc_q;
        gnt_oh_d    = gnt_oh_q;
        we_d        = we_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        sel_d       = sel_q;
        prev_busy_d = (state_q == BUSY);
        case (state_q)
            ARB: begin
                if (win_vld_s) begin
                    state_d  = BUSY;
                    acc_d    = 1'b1;
                    gnt_oh_d = NUM_PORTS'(1) << win_s;
                    we_d     = we_i[win_s];
                    adr_d    = adr_arr_s[win_s];
                    dat_d    = dat_arr_s[win_s];
                    sel_d    = sel_arr_s[win_s];
                    if (win_s == last_q) begin
                        hold_d = (hold_q == HOLD_W'(MAX_HOLD)) ? hold_q : hold_q + HOLD_W'(1);
                    end else begin
                        hold_d = HOLD_W'(1);
                        last_d = win_s;
                    end
                end else begin
                    hold_d = '0;
                end
            end
            BUSY: begin
                if (ctrl_ack_i) begin
                    state_d  = ARB;
                    acc_d    = 1'b0;
                    gnt_oh_d = '0;
                end else begin
                    state_d  = BUSY;
                end
            end
            default: begin
                state_d  = ARB;
                acc_d    = 1'b0;
                gnt_oh_d = '0;
            end
        endcase
    end

    // State and request-field registers.
    always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
        if (!sdram_rst_n) begin
            state_q     <= ARB;
            last_q      <= IDX_W'(NUM_PORTS - 1);
            hold_q      <= '0;
            acc_q       <= 1'b0;
            prev_busy_q <= 1'b0;
            gnt_oh_q    <= '0;
            we_q        <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            acc_q       <= acc_d;
            prev_busy_q <= prev_busy_d;
            gnt_oh_q    <= gnt_oh_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            sel_q       <= sel_d;
        end
    end

    // acc drops in the ack cycle so the controller never samples a second request.
    assign ctrl_acc_o = acc_q & ~ctrl_ack_i;
    assign ctrl_we_o  = we_q;
    assign ctrl_adr_o = adr_q;
    assign ctrl_dat_o = dat_q;
    assign ctrl_sel_o = sel_q;
    assign grant_o    = gnt_oh_q;
    assign ack_o      = gnt_oh_q & {NUM_PORTS{ctrl_ack_i}};
    assign dat_o      = (|ack_o) ? ctrl_dat_i : '0;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: vector table plus scoreboard of expected transactions, checked at each ack.
module tb_sdram_port_arbiter;

    localparam int NP = 2;
    localparam int PW = 1;

    typedef struct {
        logic [PW-1:0] port;
        logic          we;
        logic [31:0]   adr;
        logic [15:0]   dat;
        logic [1:0]    sel;
        logic [15:0]   rdat;
        logic          drop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NP-1:0] req_i, we_i;
    logic [NP-1:0][31:0] adr_a;
    logic [NP-1:0][15:0] dat_a;
    logic [NP-1:0][1:0] sel_a;
    logic [NP-1:0] ack_o, grant_o;
    logic [15:0] dat_o, ctrl_dat_o, ctrl_dat_i;
    logic ctrl_acc_o, ctrl_we_o, ctrl_ack_i;
    logic [31:0] ctrl_adr_o;
    logic [1:0] ctrl_sel_o;

    vec_t sb[$];
    vec_t vecs[5];
    vec_t mon_e;
    vec_t tmp;
    int total = 0;
    int bad = 0;
    int resp_cnt = 0;
    int stray_req_n = 0;
    int stray_done_n = 0;
    int n_ack;
    bit got;

    always #5 clk = ~clk;

    sdram_port_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(4)) dut (
        .sdram_clk(clk), .sdram_rst_n(rst_n),
        .req_i(req_i), .we_i(we_i), .adr_i(adr_a), .dat_i(dat_a), .sel_i(sel_a),
        .ack_o(ack_o), .dat_o(dat_o),
        .ctrl_acc_o(ctrl_acc_o), .ctrl_we_o(ctrl_we_o), .ctrl_adr_o(ctrl_adr_o),
        .ctrl_dat_o(ctrl_dat_o), .ctrl_sel_o(ctrl_sel_o),
        .ctrl_ack_i(ctrl_ack_i), .ctrl_dat_i(ctrl_dat_i), .grant_o(grant_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_port(input logic [PW-1:0] p, input logic we, input logic [31:0] adr,
                            input logic [15:0] dat, input logic [1:0] sel);
        we_i[p]  = we;
        adr_a[p] = adr;
        dat_a[p] = dat;
        sel_a[p] = sel;
    endtask

    task automatic wait_ack(input int limit, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < limit && !ok; k++) begin
            @(negedge clk);
            #4;
            if (ack_o != '0) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ack within %0d cycles", limit);
        end
    endtask

    // Controller model: ack two cycles after acc is first seen, one-cycle pulse, plus stray acks on demand.
    initial begin
        ctrl_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (ctrl_ack_i) begin
                ctrl_ack_i = 1'b0;
                resp_cnt   = 0;
            end else if (stray_req_n != stray_done_n) begin
                ctrl_ack_i   = 1'b1;
                stray_done_n = stray_req_n;
            end else if (ctrl_acc_o) begin
                resp_cnt++;
                if (resp_cnt >= 2) ctrl_ack_i = 1'b1;
            end else begin
                resp_cnt = 0;
            end
        end
    end

    // Scoreboard monitor: every cycle with an ack pops one expected transaction.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (ack_o != '0) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: got ack_o=%b want none", ack_o);
                end else begin
                    mon_e = sb.pop_front();
                    chk("ack_onehot", 32'(ack_o), 32'(2'b01 << mon_e.port));
                    chk("ctrl_adr", ctrl_adr_o, mon_e.adr);
                    chk("ctrl_dat", 32'(ctrl_dat_o), 32'(mon_e.dat));
                    chk("ctrl_we", 32'(ctrl_we_o), 32'(mon_e.we));
                    chk("ctrl_sel", 32'(ctrl_sel_o), 32'(mon_e.sel));
                    chk("rd_dat", 32'(dat_o), 32'(mon_e.rdat));
                    chk("acc_low_in_ack", 32'(ctrl_acc_o), 32'd0);
                end
            end
        end
    end

    initial begin
        req_i = '0; we_i = '0; adr_a = '0; dat_a = '0; sel_a = '0; ctrl_dat_i = '0;
        vecs[0] = '{1'b0, 1'b1, 32'h0000_1000, 16'hBEEF, 2'b11, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 32'h2000_0040, 16'h0000, 2'b11, 16'h1234, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 32'hFFFF_FFFE, 16'h5555, 2'b10, 16'hA5A5, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0002, 16'hCAFE, 2'b01, 16'h0F0F, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 32'h8000_0000, 16'h0001, 2'b00, 16'hFFFF, 1'b0};

        #12;
        chk("rst_acc", 32'(ctrl_acc_o), 32'd0);
        chk("rst_adr", ctrl_adr_o, 32'd0);
        chk("rst_dat", 32'(ctrl_dat_o), 32'd0);
        chk("rst_we_sel", 32'({ctrl_we_o, ctrl_sel_o}), 32'd0);
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single transactions; the granted port's inputs are scrambled while it is BUSY.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_port(vecs[i].port, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel);
            ctrl_dat_i = vecs[i].rdat;
            req_i[vecs[i].port] = 1'b1;
            sb.push_back(vecs[i]);
            @(negedge clk);
            chk("acc_latency", 32'(ctrl_acc_o), 32'd1);
            chk("grant_busy", 32'(grant_o), 32'(2'b01 << vecs[i].port));
            set_port(vecs[i].port, ~vecs[i].we, ~vecs[i].adr, ~vecs[i].dat, ~vecs[i].sel);
            if (vecs[i].drop) req_i[vecs[i].port] = 1'b0;
            wait_ack(20, got);
            @(negedge clk);
            req_i = '0;
            repeat (2) @(negedge clk);
        end

        // Both ports request continuously: four grants each, starting at port 0.
        @(negedge clk);
        set_port(1'b0, 1'b0, 32'h0000_0100, 16'h1111, 2'b11);
        set_port(1'b1, 1'b0, 32'h0000_0200, 16'h2222, 2'b11);
        ctrl_dat_i = 16'h7777;
        for (int i = 0; i < 12; i++) begin
            tmp.port = PW'((i / 4) % 2);
            tmp.we   = 1'b0;
            tmp.adr  = (tmp.port == 1'b0) ? 32'h0000_0100 : 32'h0000_0200;
            tmp.dat  = (tmp.port == 1'b0) ? 16'h1111 : 16'h2222;
            tmp.sel  = 2'b11;
            tmp.rdat = 16'h7777;
            tmp.drop = 1'b0;
            sb.push_back(tmp);
        end
        req_i = 2'b11;
        n_ack = 0;
        for (int k = 0; k < 300 && n_ack < 12; k++) begin
            @(negedge clk);
            #4;
            if (ack_o != '0) n_ack++;
        end
        chk("rr_ack_count", 32'(n_ack), 32'd12);
        @(negedge clk);
        req_i = '0;
        repeat (3) @(negedge clk);

        // Stray ack with no requests must not reach any port.
        stray_req_n++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #4;
            chk("stray_ack", 32'(ack_o), 32'd0);
            chk("stray_idle", 32'({grant_o, ctrl_acc_o}), 32'd0);
        end

        // Asynchronous reset in the middle of a transaction, then port 0 must win first.
        @(negedge clk);
        set_port(1'b0, 1'b1, 32'h0000_3000, 16'h3333, 2'b01);
        req_i = 2'b01;
        @(negedge clk);
        chk("pre_rst_acc", 32'(ctrl_acc_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", 32'(ctrl_acc_o), 32'd0);
        chk("mid_rst_ack_grant", 32'({ack_o, grant_o}), 32'd0);
        chk("mid_rst_adr", ctrl_adr_o, 32'd0);
        req_i = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_port(1'b0, 1'b0, 32'h0000_4000, 16'h4444, 2'b11);
        set_port(1'b1, 1'b0, 32'h0000_5000, 16'h5555, 2'b11);
        ctrl_dat_i = 16'h9999;
        sb.push_back('{1'b0, 1'b0, 32'h0000_4000, 16'h4444, 2'b11, 16'h9999, 1'b0});
        req_i = 2'b11;
        wait_ack(20, got);
        @(negedge clk);
        req_i = '0;

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
